// File: rtl/mem_arbiter.sv
// mem_arbiter: single RAM port shared by icache and dcache, D priority with bounded I starvation
// Ports: CLK/RST (sync, active-high); iREN/iaddr -> iwait/iload (icache side);
// dREN/dWEN/daddr/dstore -> dwait/dload (dcache side); ramREN/ramWEN/ramaddr/ramstore
// to the RAM, ramload/ramstate from it; gnt exposes the current grant state.
module mem_arbiter #(
   parameter int WORD_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic [1:0]        gnt
);
   typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;
   localparam logic [1:0] ACCESS = 2'd2;
   state_t     state;
   logic [2:0] starve_cnt;
   logic       dreq, starve, idone, ddone;
   assign dreq   = dREN | dWEN;
   assign starve = iREN && starve_cnt == 3'(STARVE_LIMIT);
   // completion needs the enable still up; a reset cycle never completes
   assign idone  = state == SERVE_I && iREN && ramstate == ACCESS && !RST;
   assign ddone  = state == SERVE_D && dreq && ramstate == ACCESS && !RST;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE:
               if (dreq && !starve) begin
                  state      <= SERVE_D;
                  starve_cnt <= !iREN ? 3'd0 : starve_cnt == 3'd7 ? 3'd7 : starve_cnt + 3'd1;
               end else if (iREN) begin
                  state      <= SERVE_I;
                  starve_cnt <= '0;
               end
            SERVE_I: if (!iREN || idone) state <= IDLE;
            SERVE_D: if (!dreq || ddone) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   always_comb begin
      ramREN   = state == SERVE_I ? iREN : state == SERVE_D ? dREN & ~dWEN : 1'b0;
      ramWEN   = state == SERVE_D ? dWEN : 1'b0;
      ramaddr  = state == SERVE_I ? iaddr : state == SERVE_D ? daddr : '0;
      ramstore = state == SERVE_D ? dstore : '0;
      iwait    = ~idone;
      dwait    = ~ddone;
      iload    = idone ? ramload : '0;
      dload    = ddone ? ramload : '0;
      gnt      = state;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
   localparam int W = 32, LIM = 4;
   logic CLK = 0, RST = 0, iREN = 0, dREN = 0, dWEN = 0;
   logic [W-1:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
   logic [1:0] ramstate = 0;
   logic iwait, dwait, ramREN, ramWEN;
   logic [W-1:0] iload, dload, ramaddr, ramstore;
   logic [1:0] gnt;
   int checks = 0, errors = 0;
   int owner = 0, streak = 0;
   bit known = 0, last_idone = 0, last_ddone = 0;
   always #5 CLK = ~CLK;
   mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIM)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .gnt(gnt));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask
   // owner: 0 nobody, 1 icache, 2 dcache; streak: D grants in a row made while I was waiting
   task automatic cycle();
      bit di, dd, dq, eren, ewen;
      logic [31:0] ea, es;
      int nxt;
      #1;
      dq = dREN | dWEN;
      di = owner == 1 && iREN && ramstate == 2 && !RST;
      dd = owner == 2 && dq && ramstate == 2 && !RST;
      eren = owner == 1 ? iREN : owner == 2 ? dREN && !dWEN : 0;
      ewen = owner == 2 && dWEN;
      ea = owner == 1 ? iaddr : owner == 2 ? daddr : 0;
      es = owner == 2 ? dstore : 0;
      if (known) begin
         check("gnt", 32'(gnt), 32'(owner));
         check("iwait", 32'(iwait), 32'(!di));
         check("dwait", 32'(dwait), 32'(!dd));
         check("iload", iload, di ? ramload : 0);
         check("dload", dload, dd ? ramload : 0);
         check("ramREN", 32'(ramREN), 32'(eren));
         check("ramWEN", 32'(ramWEN), 32'(ewen));
         check("ramaddr", ramaddr, ea);
         check("ramstore", ramstore, es);
      end
      nxt = owner;
      if (owner == 0) begin
         if (dq && !(streak == LIM && iREN)) begin
            nxt = 2;
            streak = iREN ? (streak < 7 ? streak + 1 : 7) : 0;
         end else if (iREN) begin
            nxt = 1;
            streak = 0;
         end
      end else if (owner == 1 && (!iREN || di)) nxt = 0;
      else if (owner == 2 && (!dq || dd)) nxt = 0;
      last_idone = di;
      last_ddone = dd;
      @(posedge CLK);
      owner = nxt;
      if (RST) begin
         owner = 0;
         streak = 0;
         known = 1;
      end
      #1;
   endtask
   initial begin
      int pulses;
      logic [1:0] r;
      // reset with random request inputs
      RST = 1;
      for (int k = 0; k < 2; k++) begin
         iREN = 1'($urandom); dREN = 1'($urandom); dWEN = 1'($urandom);
         iaddr = $urandom; daddr = $urandom; dstore = $urandom;
         ramstate = 2'($urandom); ramload = $urandom;
         cycle();
      end
      RST = 0; iREN = 0; dREN = 0; dWEN = 0; ramstate = 0;
      cycle();
      // I read, one BUSY then ACCESS
      iREN = 1; iaddr = 32'h40;
      cycle();
      ramstate = 1;
      cycle();
      ramstate = 2; ramload = 32'hDEADBEEF;
      #1 check("iread_iload", iload, 32'hDEADBEEF);
      cycle();
      iREN = 0; ramstate = 0;
      cycle();
      // simultaneous I read and D write: D first
      iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'h1234;
      cycle();
      check("simul_first_addr", ramaddr, 32'h100);
      ramstate = 2;
      cycle();
      dWEN = 0; ramstate = 0;
      cycle();
      check("simul_second_addr", ramaddr, 32'h80);
      ramstate = 2;
      cycle();
      iREN = 0; ramstate = 0;
      cycle();
      // starvation: both held, latency 1
      dREN = 1; iREN = 1;
      for (int g = 0; g < 10; g++) begin
         ramstate = 0;
         cycle();
         check("starve_seq", 32'(gnt), (g % 5 == 4) ? 32'd1 : 32'd2);
         ramstate = 1;
         cycle();
         ramstate = 2;
         cycle();
      end
      dREN = 0; iREN = 0; ramstate = 0;
      cycle();
      // ERROR retry on a D write
      dWEN = 1; daddr = 32'h200; dstore = 32'h55AA;
      cycle();
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         ramstate = k < 2 ? 2'd3 : 2'd2;
         #1;
         if (!dwait) pulses++;
         check("err_wen_held", 32'(ramWEN), 32'd1);
         cycle();
      end
      check("err_pulses", 32'(pulses), 32'd1);
      dWEN = 0; ramstate = 0;
      cycle();
      // abort: dREN dropped mid access
      dREN = 1; daddr = 32'h300;
      cycle();
      ramstate = 1;
      cycle();
      dREN = 0; ramstate = 2;
      cycle();
      check("abort_idle", 32'(gnt), 32'd0);
      ramstate = 0;
      cycle();
      // reset mid SERVE_I, then a normal I read
      iREN = 1; iaddr = 32'h500;
      cycle();
      ramstate = 1;
      cycle();
      RST = 1;
      cycle();
      check("rst_idle", 32'(gnt), 32'd0);
      RST = 0; ramstate = 0;
      cycle();
      ramstate = 2; ramload = 32'hCAFE0001;
      cycle();
      iREN = 0; ramstate = 0;
      cycle();
      // randomized traffic honouring the hold-while-waiting rule
      for (int n = 0; n < 3000; n++) begin
         if (!iREN || last_idone) begin
            iREN = 1'($urandom); iaddr = $urandom;
         end else if ($urandom_range(0, 31) == 0) iREN = 0;
         if (!(dREN | dWEN) || last_ddone) begin
            r = 2'($urandom); dREN = r[0]; dWEN = r[1]; daddr = $urandom; dstore = $urandom;
         end else if ($urandom_range(0, 31) == 0) begin
            dREN = 0; dWEN = 0;
         end
         ramstate = 2'($urandom); ramload = $urandom;
         RST = $urandom_range(0, 199) == 0;
         cycle();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction cache and the data cache. It sits below the `caches` block and grants the one RAM port to one requester at a time, with data-side priority and bounded instruction starvation. It routes that requester's address, store data and enables to the RAM, and returns wait/load responses.

## Interface
Parameters:
- WORD_W, 32, width of addresses and data words
- STARVE_LIMIT, 4, maximum consecutive D grants made while iREN is pending before I must be granted (range 1–7)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache address
- iwait  out  1  low only in the cycle an I access completes
- iload  out  WORD_W  ramload in the I completion cycle, else 0
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  WORD_W  dcache address
- dstore  in  WORD_W  dcache store data
- dwait  out  1  low only in the cycle a D access completes
- dload  out  WORD_W  ramload in the D completion cycle, else 0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- gnt  out  2  current state: 0 IDLE, 1 SERVE_I, 2 SERVE_D

## Operation
- Request rules:
  - Requesters hold their request and operands stable while their wait is high.
  - dREN and dWEN both high is treated as a write; dWEN wins.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - If a D request is present and not starving I, go to SERVE_D.
  - Otherwise, if iREN, go to SERVE_I.
  - Otherwise stay in IDLE.
- Starvation check: when starve_cnt == STARVE_LIMIT and iREN is high, I is granted even if D is requesting.
- starve_cnt (3-bit):
  - On a D grant with iREN high: increment, saturating at 7.
  - On a D grant with iREN low: clear to 0.
  - On any I grant: clear to 0.
- SERVE_x, RAM outputs (combinational from state and that requester's current inputs):
  - SERVE_I: ramREN = iREN, ramaddr = iaddr, ramWEN = 0, ramstore = 0.
  - SERVE_D: ramREN = dREN & ~dWEN, ramWEN = dWEN, ramaddr = daddr, ramstore = dstore.
  - In IDLE all RAM outputs are 0.
- SERVE_x, transitions and responses:
  - ramstate == ACCESS: completion. The granted wait goes low and its load = ramload for that cycle; next state IDLE.
  - ramstate == ERROR: treated as BUSY. Stay in the state with the request held, so the access is retried; no completion is signalled.
  - Requester drops its enable before completion: abort. RAM enables fall that same cycle; next state IDLE; no completion is signalled.
- The wait of the non-granted requester stays high throughout.
- Reset:
  - Next edge forces IDLE and starve_cnt = 0.
  - Outputs then read iwait = dwait = 1, iload = dload = 0, all ram* outputs 0, gnt = 0.
  - Reset mid-access abandons the access; no completion is signalled.

## Timing
- Request seen in IDLE at edge N: gnt and RAM enables valid from cycle N+1.
- Completion occurs in the first SERVE cycle where ramstate == ACCESS. With a RAM showing ACCESS k cycles after enable, wait is low in cycle N+1+k.
- Every completion is followed by one mandatory IDLE cycle. Back-to-back accesses therefore cost (k+2) cycles each, minimum 2.
- A request arriving in the completion cycle is arbitrated in the following IDLE cycle.
- iREN and a D request arriving in the same IDLE cycle: D wins unless the starvation condition holds.
- Wait and load outputs are combinational in the completion cycle; there are no registered data outputs.

## Test plan
- Reset: assert RST for 2 cycles with random request inputs -> iwait = dwait = 1, iload = dload = 0, ramREN = ramWEN = 0, gnt = 0 after the first edge.
- I read: iREN = 1, iaddr = 0x40; the RAM gives BUSY for 1 cycle then ACCESS with ramload = 0xDEADBEEF -> ramREN = 1 and ramaddr = 0x40 in cycles 1–2; iwait = 0 and iload = 0xDEADBEEF only in cycle 2; gnt = 0 in cycle 3.
- Simultaneous requests: iREN (iaddr = 0x80) and dWEN (daddr = 0x100, dstore = 0x1234) in the same cycle -> ramWEN = 1, ramaddr = 0x100, ramstore = 0x1234 first. dwait completes, then IDLE, then ramREN with ramaddr = 0x80.
- Starvation: dREN and iREN held high continuously, STARVE_LIMIT = 4, RAM latency 1 -> grant sequence D, D, D, D, I, D, …; starve_cnt = 0 after the I grant.
- ERROR retry: in SERVE_D, ramstate goes ERROR, ERROR, then ACCESS -> dwait low exactly once, on the ACCESS cycle; ramWEN held high across all three cycles.
- Abort and reset: dREN dropped mid-SERVE_D -> ramREN falls the same cycle and IDLE follows with no dwait pulse. Separately, RST asserted mid-SERVE_I -> IDLE next edge, no iwait pulse, and a new iREN is served normally afterwards.
